io_input_unit: RTL

IO_INPUT_UNIT -- requirements
Module: io_input_unit

---
 rtl/io_input_unit_if.sv | 31 +++
 rtl/io_input_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/io_input_unit_if.sv
// Bus bundle for io_input_unit: device-side character handshake plus the
// control-unit strobes and the serial/status outputs toward accumulator C.
interface io_input_unit_if #(
  parameter int CHAR_BITS = 4
);
  // device side
  logic                 dev_valid;
  logic [CHAR_BITS-1:0] dev_data;
  logic                 dev_ready;
  // control-unit side
  logic                 do_input_start;
  logic                 do_left_shift_c;
  logic                 do_clear_err;
  logic                 io_input_data;
  logic                 input_busy;
  logic                 input_done;
  logic                 buf_empty;
  logic                 err_flag;

  // Environment view: drives device data and control strobes.
  modport master (
    output dev_valid, dev_data, do_input_start, do_left_shift_c, do_clear_err,
    input  dev_ready, io_input_data, input_busy, input_done, buf_empty, err_flag
  );

  // Unit view.
  modport slave (
    input  dev_valid, dev_data, do_input_start, do_left_shift_c, do_clear_err,
    output dev_ready, io_input_data, input_busy, input_done, buf_empty, err_flag
  );
endinterface

// File: rtl/io_input_unit.sv
// Input unit: buffers device characters in a small FIFO and serialises one
// character MSB-first into accumulator C, one bit per shift pulse.
module io_input_unit #(
  parameter int CHAR_BITS  = 4,  // 1..8
  parameter int FIFO_DEPTH = 2   // power of two, >= 2
) (
  input  logic            clk,
  input  logic            reset,
  io_input_unit_if.slave  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(CHAR_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [CHAR_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q,  count_d;
  logic                 full, empty, push, pop;
  logic [CHAR_BITS-1:0] head;

  // ---------------------------------------------------------------- FSM
  state_t               state_q;
  logic [CHAR_BITS-1:0] sreg_q;
  logic [NW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q, err_d;
  logic                 err_set;

  // Status is decoded from the registered occupancy only, so a character
  // pushed this cycle becomes visible (and poppable) on the next one.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.dev_valid && !full;
  assign pop   = !empty &&
                 (((state_q == S_IDLE) && bus.do_input_start) ||
                   (state_q == S_WAIT));

  // Pointer and occupancy next-state; pointers wrap naturally at PW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while count is 0, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.dev_data;
  end

  // Transfer FSM with registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.do_input_start) begin
            busy_q <= 1'b1;
            if (!empty) begin
              sreg_q  <= head;
              cnt_q   <= NW'(CHAR_BITS);
              state_q <= S_SHIFT;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!empty) begin
            sreg_q  <= head;
            cnt_q   <= NW'(CHAR_BITS);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // No pulse means hold: the control unit may stall indefinitely.
          if (bus.do_left_shift_c) begin
            sreg_q <= sreg_q << 1;
            cnt_q  <= cnt_q - NW'(1);
            if (cnt_q == NW'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Protocol errors: start while not idle, shift while not shifting.
  // A new error wins over a same-cycle clear.
  assign err_set = (bus.do_input_start  && (state_q != S_IDLE)) ||
                   (bus.do_left_shift_c && (state_q != S_SHIFT));

  always_comb begin
    err_d = err_q;
    if (err_set)               err_d = 1'b1;
    else if (bus.do_clear_err) err_d = 1'b0;
  end

  // Sticky error flag register.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.dev_ready     = !full;
  assign bus.buf_empty     = empty;
  assign bus.io_input_data = (state_q == S_SHIFT) && sreg_q[CHAR_BITS-1];
  assign bus.input_busy    = busy_q;
  assign bus.input_done    = done_q;
  assign bus.err_flag      = err_q;

endmodule
